disp_chan_mux: RTL
==================

# disp_chan_mux

Parametrised display-channel multiplexer, the next generation of the 8×32 display selector. It feeds the seven-segment/LED display driver and selects one of CH_NUM data channels plus per-channel blink (LE) and point masks. Channel 0 is a CPU-written shadow register loaded on EN. Outputs are registered, and an optional auto-scan mode steps through channels on a programmable dwell counter.

## Interface
Parameters:
- CH_NUM, 8: number of channels, 2..16.
- DW, 32: display data width per channel.
- MW, 8: blink/point mask width per channel.
- DWELL_W, 24: width of the dwell counter and the `dwell` input.

Ports:
- clk, input, 1: single clock; all state is updated on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- EN, input, 1: load the channel 0 shadow from `data_in[DW-1:0]`, `LES[MW-1:0]` and `point_in[MW-1:0]`.
- Test, input, SW=$clog2(CH_NUM): manual channel select.
- scan_en, input, 1: auto-scan mode enable.
- dwell, input, DWELL_W: cycles per channel in scan mode, minus 1.
- hold, input, 1: freeze all output registers.
- data_in, input, CH_NUM*DW: channel data, channel i at bits [i*DW +: DW].
- LES, input, CH_NUM*MW: blink masks, packed like `data_in`.
- point_in, input, CH_NUM*MW: point masks, packed like `data_in`.
- Disp_num, output, DW: selected data (registered).
- LE_out, output, MW: selected blink mask (registered).
- point_out, output, MW: selected point mask (registered).
- cur_ch, output, SW: channel currently shown on the outputs.
- ch_step, output, 1: one-cycle pulse when the scan advances.

## Operation
- Channel 0 shadow (`sh_data`, `sh_blink`, `sh_point`):
  - Loaded when EN=1; otherwise holds its value.
  - Reset values: `sh_data`=32'hAA5555AA (zero-extended or truncated to DW), `sh_blink`=all ones, `sh_point`=0.
- Channels 1..CH_NUM-1 are selected directly from the input buses with no shadow.
- Selection index `sel`:
  - When scan_en=0: `sel`=Test. A Test value ≥ CH_NUM selects channel 0.
  - When scan_en=1: `sel` is the scan index.
- Scan controller states:
  - IDLE: scan_en=0. Counter = 0. The scan index tracks Test, so a scan always starts from the manually selected channel.
  - SCAN: scan_en=1. The counter increments every cycle.
  - When counter == dwell: the counter clears, the index advances (CH_NUM-1 wraps to 0), and ch_step pulses.
  - dwell=0: the index advances every cycle.
  - Deasserting scan_en returns to IDLE next cycle; the counter clears.
- hold=1: Disp_num, LE_out, point_out and cur_ch keep their values.
  - The shadow still loads on EN.
  - The scan counter and index keep running.
- Output registers load `mux(sel)` each cycle unless hold=1.
- Reset values of outputs: Disp_num=32'hAA5555AA, LE_out=all ones, point_out=0, cur_ch=0, ch_step=0.

## Timing
- Channels 1..CH_NUM-1: an input sampled at edge k appears on the outputs after edge k+1. Latency is 1 cycle.
- Channel 0: EN with Data at edge k loads the shadow; the value appears on Disp_num after edge k+1. Latency is 2 cycles.
  - If EN coincides with sel=0, the output shows the old shadow for that cycle.
- Test change at edge k: the outputs and cur_ch show the new channel after edge k+1.
- Scan: ch_step is high for exactly one cycle, aligned with the cycle in which the index changes. cur_ch follows one cycle later.
- scan_en rising at edge k: the first advance happens dwell+1 cycles later.
- Reset asserted mid-scan or mid-hold: every register goes immediately to its reset value. After release, scanning restarts from Test with counter 0.
- Simultaneous hold and ch_step: the step is taken internally; the outputs show the new channel on the first cycle after hold drops.

## Configuration
- DISP_AUTO_SCAN_EN defined: the scan controller, dwell counter and ch_step are built as described above.
- Not defined:
  - scan_en and dwell are ignored; `sel`=Test always.
  - ch_step is tied to 0; no counter logic is synthesised.
  - All other behaviour is identical.

## Structure
- Package disp_mux_pkg holds:
  - constants DISP_RST_DATA (32'hAA5555AA), DISP_RST_BLINK (all ones), DISP_RST_POINT (0);
  - the scan state enum (IDLE, SCAN);
  - a clog2 helper function.
- Sub-module disp_scan_ctr holds the dwell counter, scan index, state and ch_step. It is instantiated only under DISP_AUTO_SCAN_EN.

## Test plan
- Reset, then CH_NUM=8, Test=0, no EN → Disp_num=AA5555AA, LE_out=FF, point_out=00, cur_ch=0.
- Test=0, EN=1 for one cycle with data_in[31:0]=12345678, LES[7:0]=0F → Disp_num=12345678 and LE_out=0F two cycles later; the value holds after EN drops even when the inputs change.
- Test=3 with data_in ch3=DEADBEEF → Disp_num=DEADBEEF one cycle later. Then Test=9 at CH_NUM=10, and Test=15 (≥ CH_NUM, selects channel 0) → Disp_num shows the shadow.
- Scan enabled with dwell=2 from Test=6 → cur_ch sequence 6,6,6,7,7,7,0,0,0,1 with ch_step pulsing every 3 cycles; the wrap 7→0 is checked.
- hold=1 during scan for 10 cycles → outputs frozen while ch_step keeps pulsing. Drop hold → outputs jump to the current index.
- rst asserted mid-scan at index 5 → outputs return to reset values immediately. After release with scan_en=1 and Test=2, scanning restarts at 2 with a full dwell.

Source files
------------

// File: rtl/disp_mux_pkg.sv
// Shared constants, scan state type and sizing helper for the display channel multiplexer.
package disp_mux_pkg;

    localparam logic [31:0] DISP_RST_DATA  = 32'hAA5555AA;
    localparam logic [63:0] DISP_RST_BLINK = '1;
    localparam logic [63:0] DISP_RST_POINT = '0;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_scan_ctr.sv
// Auto-scan controller: dwell counter, scan index and one-cycle ch_step pulse.
// Only instantiated when DISP_AUTO_SCAN_EN is defined.
module disp_scan_ctr
    import disp_mux_pkg::*;
#(
    parameter int CH_NUM  = 8,
    parameter int SW      = 3,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_en_i,
    input  logic [SW-1:0]      start_ch_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [SW-1:0]      idx_o,
    output scan_state_e        state_o,
    output logic               ch_step_o
);

    scan_state_e        state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]      idx_q, idx_d;
    logic               step_q, step_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
        end
    end

    // While idle the index shadows the manual channel, so a scan starts from it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = start_ch_i;
                if (scan_en_i) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!scan_en_i) begin
                    state_d = IDLE;
                    idx_d   = start_ch_i;
                end else if (cnt_q == dwell_i) begin
                    idx_d  = (idx_q == SW'(CH_NUM - 1)) ? '0 : idx_q + SW'(1);
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx_o     = idx_q;
    assign state_o   = state_q;
    assign ch_step_o = step_q;

endmodule

// File: rtl/disp_chan_mux.sv
// Display channel multiplexer with channel 0 shadow and registered outputs.
// Define DISP_AUTO_SCAN_EN to build the auto-scan controller.
module disp_chan_mux
    import disp_mux_pkg::*;
#(
    parameter int CH_NUM  = 8,
    parameter int DW      = 32,
    parameter int MW      = 8,
    parameter int DWELL_W = 24,
    localparam int SW     = clog2(CH_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN,
    input  logic [SW-1:0]        Test,
    input  logic                 scan_en,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 hold,
    input  logic [CH_NUM*DW-1:0] data_in,
    input  logic [CH_NUM*MW-1:0] LES,
    input  logic [CH_NUM*MW-1:0] point_in,
    output logic [DW-1:0]        Disp_num,
    output logic [MW-1:0]        LE_out,
    output logic [MW-1:0]        point_out,
    output logic [SW-1:0]        cur_ch,
    output logic                 ch_step
);

    logic [DW-1:0] sh_data_q;
    logic [MW-1:0] sh_blink_q, sh_point_q;
    logic [DW-1:0] disp_q;
    logic [MW-1:0] le_q, point_q;
    logic [SW-1:0] cur_q;
    logic [SW-1:0] test_c, sel;
    logic [DW-1:0] mux_data;
    logic [MW-1:0] mux_blink, mux_point;

    // Out-of-range manual selects fall back to the shadow channel.
    assign test_c = (int'(Test) < CH_NUM) ? Test : '0;

`ifdef DISP_AUTO_SCAN_EN
    logic [SW-1:0] scan_idx;
    scan_state_e   scan_state;

    disp_scan_ctr #(
        .CH_NUM (CH_NUM),
        .SW     (SW),
        .DWELL_W(DWELL_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .scan_en_i (scan_en),
        .start_ch_i(test_c),
        .dwell_i   (dwell),
        .idx_o     (scan_idx),
        .state_o   (scan_state),
        .ch_step_o (ch_step)
    );

    assign sel = (scan_en && scan_state == SCAN) ? scan_idx : test_c;
`else
    logic unused_scan;
    assign unused_scan = ^{scan_en, dwell};
    assign sel         = test_c;
    assign ch_step     = 1'b0;
`endif

    always_comb begin
        mux_data  = sh_data_q;
        mux_blink = sh_blink_q;
        mux_point = sh_point_q;
        if (sel != '0) begin
            mux_data  = data_in[int'(sel)*DW +: DW];
            mux_blink = LES[int'(sel)*MW +: MW];
            mux_point = point_in[int'(sel)*MW +: MW];
        end
    end

    // The shadow loads on EN regardless of hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data_q  <= DW'(DISP_RST_DATA);
            sh_blink_q <= MW'(DISP_RST_BLINK);
            sh_point_q <= MW'(DISP_RST_POINT);
        end else if (EN) begin
            sh_data_q  <= data_in[DW-1:0];
            sh_blink_q <= LES[MW-1:0];
            sh_point_q <= point_in[MW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q  <= DW'(DISP_RST_DATA);
            le_q    <= MW'(DISP_RST_BLINK);
            point_q <= MW'(DISP_RST_POINT);
            cur_q   <= '0;
        end else if (!hold) begin
            disp_q  <= mux_data;
            le_q    <= mux_blink;
            point_q <= mux_point;
            cur_q   <= sel;
        end
    end

    assign Disp_num  = disp_q;
    assign LE_out    = le_q;
    assign point_out = point_q;
    assign cur_ch    = cur_q;

endmodule
